// File: rtl/bsg_round_robin_n_to_1_packet_if.sv
// Handshake bundle between N valid/yumi producers and the packet arbiter.
// The slave modport is the arbiter's view; master is the producer/consumer environment.
interface bsg_round_robin_n_to_1_packet_if #(
  parameter int num_in_p     = 4,
  parameter int width_p      = 16,
  parameter int tag_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
);
  logic [num_in_p*width_p-1:0] data_i;
  logic [num_in_p-1:0]         v_i;
  logic [num_in_p-1:0]         last_i;
  logic [num_in_p-1:0]         yumi_o;
  logic                        v_o;
  logic [width_p-1:0]          data_o;
  logic                        last_o;
  logic [tag_width_lp-1:0]     tag_o;
  logic                        yumi_i;

  modport slave (
    input  data_i, v_i, last_i, yumi_i,
    output yumi_o, v_o, data_o, last_o, tag_o
  );

  modport master (
    output data_i, v_i, last_i, yumi_i,
    input  yumi_o, v_o, data_o, last_o, tag_o
  );
endinterface

// File: rtl/bsg_round_robin_n_to_1_packet.sv
// Quota-weighted round-robin packet arbiter, N inputs to 1; zero-cycle combinational grant path.
// Backpressure: yumi_i low holds grant and state; a granted packet owns the output until its last beat.
module bsg_round_robin_n_to_1_packet #(
  parameter int num_in_p = 4,
  parameter int width_p  = 16,
  parameter int quota_p  = 2
) (
  input logic clk_i,
  input logic reset_i,
  bsg_round_robin_n_to_1_packet_if.slave io
);

  localparam int tag_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int cnt_w_lp     = $clog2(quota_p + 1);

  localparam logic [tag_width_lp:0]   num_lp      = (tag_width_lp + 1)'(num_in_p);
  localparam logic [tag_width_lp-1:0] last_idx_lp = tag_width_lp'(num_in_p - 1);
  localparam logic [cnt_w_lp:0]       quota_lp    = (cnt_w_lp + 1)'(quota_p);
  localparam logic [cnt_w_lp:0]       one_lp      = (cnt_w_lp + 1)'(1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                  state_q, state_d;
  logic [tag_width_lp-1:0] owner_q, owner_d;
  logic [tag_width_lp-1:0] prio_q, prio_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;

  logic [width_p-1:0]      din [num_in_p];
  logic [tag_width_lp:0]   idx;
  logic [tag_width_lp-1:0] win;
  logic                    found;
  logic [tag_width_lp-1:0] sel;
  logic                    any_v;
  logic                    v_out;
  logic                    fire;
  logic                    last_out;
  logic [cnt_w_lp:0]       c;

  for (genvar k = 0; k < num_in_p; k++) begin : g_in
    assign din[k]       = io.data_i[k*width_p +: width_p];
    assign io.yumi_o[k] = fire & (sel == tag_width_lp'(k));
  end

  // Circular scan from prio_q with explicit wrap, so non-power-of-2 counts work.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < num_in_p; i++) begin
      idx = {1'b0, prio_q} + (tag_width_lp + 1)'(i);
      if (idx >= num_lp) idx = idx - num_lp;
      if (!found && io.v_i[idx[tag_width_lp-1:0]]) begin
        found = 1'b1;
        win   = idx[tag_width_lp-1:0];
      end
    end
  end

  assign sel      = (state_q == LOCKED) ? owner_q : win;
  assign any_v    = (state_q == LOCKED) ? io.v_i[owner_q] : found;
  assign v_out    = any_v & ~reset_i;
  assign fire     = io.yumi_i & v_out;
  assign last_out = any_v & io.last_i[sel];

  assign io.v_o    = v_out;
  assign io.tag_o  = sel;
  assign io.last_o = last_out;
  assign io.data_o = any_v ? din[sel] : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    c       = (sel == prio_q) ? ({1'b0, cnt_q} + one_lp) : one_lp;
    if (fire) begin
      if (!last_out) begin
        state_d = LOCKED;
        owner_d = sel;
      end else begin
        state_d = IDLE;
        // Turn ends after quota packets; otherwise the sender keeps top priority.
        if (c >= quota_lp) begin
          prio_d = (sel == last_idx_lp) ? '0 : sel + 1'b1;
          cnt_d  = '0;
        end else begin
          prio_d = sel;
          cnt_d  = c[cnt_w_lp-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_round_robin_n_to_1_packet.sv
// Directed scenarios followed by random traffic, checked against a packet-level arbitration model.
module tb_bsg_round_robin_n_to_1_packet;
  localparam int N = 4;
  localparam int W = 16;
  localparam int Q = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_round_robin_n_to_1_packet_if #(.num_in_p(N), .width_p(W)) io ();

  bsg_round_robin_n_to_1_packet #(.num_in_p(N), .width_p(W), .quota_p(Q)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .io     (io)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the output, whose turn it is, packets sent this turn.
  bit         m_lock;
  int         m_owner, m_prio, m_cnt;
  int         w;
  bit         ev, el;
  logic [W-1:0] dat [N];

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic y, input int exp_tag);
    logic [31:0] eyumi;
    int c;
    io.v_i    = v;
    io.last_i = l;
    io.yumi_i = y;
    io.data_i = {32'($urandom), 32'($urandom)};
    for (int k = 0; k < N; k++) dat[k] = io.data_i[k*W +: W];
    @(negedge clk);
    w  = 0;
    ev = 1'b0;
    if (m_lock) begin
      w  = m_owner;
      ev = v[w];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!ev && v[(m_prio + i) % N]) begin
          ev = 1'b1;
          w  = (m_prio + i) % N;
        end
      end
    end
    el    = ev && l[w];
    eyumi = (ev && y) ? (32'd1 << w) : 32'd0;
    if (rst) begin
      chk("v_o_in_reset", 32'(io.v_o), 32'd0);
      chk("yumi_o_in_reset", 32'(io.yumi_o), 32'd0);
    end else begin
      chk("v_o", 32'(io.v_o), 32'(ev));
      chk("tag_o", 32'(io.tag_o), 32'(w));
      chk("yumi_o", 32'(io.yumi_o), eyumi);
      if (ev) begin
        chk("data_o", 32'(io.data_o), 32'(dat[w]));
        chk("last_o", 32'(io.last_o), 32'(el));
      end
      if (exp_tag >= 0) chk("dir_tag", 32'(io.tag_o), 32'(exp_tag));
    end
    @(posedge clk);
    if (rst) begin
      m_lock = 1'b0; m_owner = 0; m_prio = 0; m_cnt = 0;
    end else if (ev && y) begin
      if (!el) begin
        m_lock  = 1'b1;
        m_owner = w;
      end else begin
        m_lock = 1'b0;
        c = (w == m_prio) ? m_cnt + 1 : 1;
        if (c >= Q) begin
          m_prio = (w + 1) % N;
          m_cnt  = 0;
        end else begin
          m_prio = w;
          m_cnt  = c;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc('0, '0, 1'b0, -1);
    cyc('0, '0, 1'b1, -1);
    rst = 1'b0;
  endtask

  initial begin
    int t1 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    m_lock = 1'b0; m_owner = 0; m_prio = 0; m_cnt = 0;
    io.v_i = '0; io.last_i = '0; io.yumi_i = 1'b0; io.data_i = '0;
    rst = 1'b1;
    #1;

    // Single-beat packets from all inputs: quota of two per turn
    do_reset();
    for (int i = 0; i < 10; i++) cyc(4'b1111, 4'b1111, 1'b1, t1[i]);

    // Three-beat packet on input 1 holds off input 2
    do_reset();
    cyc(4'b0110, 4'b0000, 1'b1, 1);
    cyc(4'b0110, 4'b0000, 1'b1, 1);
    cyc(4'b0110, 4'b0010, 1'b1, 1);
    cyc(4'b0100, 4'b0100, 1'b1, 2);

    // Owner drops valid mid-packet; others stay blocked
    do_reset();
    cyc(4'b0110, 4'b0000, 1'b1, 1);
    cyc(4'b0100, 4'b0000, 1'b1, 1);
    cyc(4'b0100, 4'b0000, 1'b1, 1);
    cyc(4'b0110, 4'b0010, 1'b1, 1);

    // Backpressure holds the grant
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'b0010, 4'b0010, 1'b0, 1);
    cyc(4'b0010, 4'b0010, 1'b1, 1);

    // Priority parked on input 3 after one packet
    do_reset();
    cyc(4'b1000, 4'b1111, 1'b1, 3);
    cyc(4'b1111, 4'b1111, 1'b1, 3);
    cyc(4'b1111, 4'b1111, 1'b1, 0);
    cyc(4'b1111, 4'b1111, 1'b1, 0);
    cyc(4'b1111, 4'b1111, 1'b1, 1);
    cyc(4'b1111, 4'b1111, 1'b1, 1);

    // Reset in the middle of a locked packet
    do_reset();
    cyc(4'b0100, 4'b0000, 1'b1, 2);
    cyc(4'b0100, 4'b0000, 1'b1, 2);
    rst = 1'b1;
    cyc(4'b0101, 4'b0000, 1'b1, -1);
    cyc(4'b0101, 4'b0000, 1'b1, -1);
    rst = 1'b0;
    cyc(4'b0101, 4'b0101, 1'b1, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0), -1);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_round_robin_n_to_1_packet.md
# bsg_round_robin_n_to_1_packet

Packet-aware, quota-weighted round-robin arbiter that funnels `num_in_p` valid/yumi input streams onto one output stream. Once a multi-beat packet is granted, the arbiter locks to that input until the beat flagged `last` is consumed. Each input may send up to `quota_p` consecutive packets before priority rotates. It sits in front of shared links and FIFOs, where packets must not be interleaved.

## Interface
Parameters:
- `num_in_p`, 4: number of inputs (≥2; need not be a power of 2).
- `width_p`, 16: data width per input.
- `quota_p`, 2: packets per turn (≥1; 1 gives plain round-robin).
- `tag_width_lp`, derived: `max(1, $clog2(num_in_p))`.

Ports:
- `clk_i`  in  1  clock; one clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `data_i`  in  `num_in_p*width_p`  input data; input k is `[k*width_p +: width_p]`.
- `v_i`  in  `num_in_p`  per-input valid.
- `last_i`  in  `num_in_p`  per-input end-of-packet flag; qualified by `v_i`.
- `yumi_o`  out  `num_in_p`  one-hot dequeue to the granted input.
- `v_o`  out  1  output valid.
- `data_o`  out  `width_p`  granted input's data.
- `last_o`  out  1  granted input's `last_i`.
- `tag_o`  out  `tag_width_lp`  index of the granted input.
- `yumi_i`  in  1  downstream consumes the current beat.

## Operation
- State:
  - `state_r` ∈ {IDLE, LOCKED}.
  - `owner_r` is the locked input.
  - `prio_r` is the highest-priority index.
  - `cnt_r` counts packets completed in the current turn, width `$clog2(quota_p+1)`.
- IDLE selection: winner w is the first k with `v_i[k]=1`, scanning `prio_r, prio_r+1, …` modulo `num_in_p` (explicit wrap at `num_in_p-1`, not power-of-2 masking).
  - `v_o = |v_i`.
  - `tag_o = w`.
  - `data_o` and `last_o` come from w.
  - When no input is valid: `tag_o=0`, `data_o=0`, `last_o=0`.
- LOCKED selection:
  - `w = owner_r`, `v_o = v_i[owner_r]`.
  - All other inputs are ignored even if valid.
  - `tag_o = owner_r` regardless of valid.
- Handshake:
  - `yumi_o[w] = yumi_i & v_o`; all other bits are 0.
  - `yumi_i` while `v_o=0` is ignored; no state change.
- Beat consumed (`yumi_i & v_o`) with `last_o=0`: go to or stay in LOCKED, `owner_r ← w`.
- Beat consumed with `last_o=1` (packet complete; includes single-beat packets taken from IDLE):
  - Go to IDLE.
  - Let `c = (w==prio_r) ? cnt_r+1 : 1`.
  - If `c ≥ quota_p`: `prio_r ← (w+1) mod num_in_p`, `cnt_r ← 0`.
  - Otherwise: `prio_r ← w`, `cnt_r ← c`.
- Priority is untouched on non-last beats.
- Reset: `state_r=IDLE`, `prio_r=0`, `cnt_r=0`, `owner_r=0`. While `reset_i=1`, `v_o=0` and `yumi_o=0` (gated).
- Reset mid-packet drops the lock. Upstream is responsible for discarding the partial packet.

## Timing
- The data path is combinational: `v_o`, `data_o`, `last_o`, `tag_o` and `yumi_o` follow the inputs and state in the same cycle, with zero-cycle latency.
- `yumi_o` depends combinationally on `yumi_i`.
- All state updates at posedge `clk_i`; the new grant takes effect the cycle after the consuming beat.
- Throughput is one beat per cycle, including back-to-back packets from different inputs. There are no bubbles on turn change.
- Backpressure (`yumi_i=0`): grant, tag and state hold. In IDLE, the grant may move if `v_i` changes, since IDLE inputs are not required to hold valid.

## Test plan
Configuration for all scenarios: `num_in_p=4`, `width_p=16`, `quota_p=2`.

1. Reset, then `v_i=1111`, `last_i=1111`, `yumi_i=1` constantly → `tag_o` sequence 0,0,1,1,2,2,3,3,0,0. `yumi_o` is one-hot matching the tag each cycle.
2. Input 1 sends a 3-beat packet (`last` on beat 3) while `v_i[2]=1` throughout → `tag_o` = 1,1,1,2. `data_o` never carries input 2 data during beats 1–3.
3. Locked on input 1 after beat 1; `v_i[1]` drops for 2 cycles while `v_i[2]=1`, `yumi_i=1` → `v_o=0` and `yumi_o=0000` for those 2 cycles. Beat 2 then resumes from input 1.
4. `v_i=0010`, `yumi_i=0` for 3 cycles → `v_o=1`, `tag_o=1`, `yumi_o=0000`, no state change. `yumi_i=1` on cycle 4 → `yumi_o=0010`.
5. After reset (`prio_r=0`), only input 3 valid with a 1-beat packet (so `prio_r←3`, `cnt_r←1`); then `v_i=1111`, all last → tags 3,0,0,1,1.
6. `reset_i` asserted in the middle of a locked packet on input 2, then released with `v_i=0101` → `v_o=0` during reset. Tag 0 in the first cycle after reset; the lock is gone.
